// File: rtl/eth_arb_pkg.sv
// Shared types and helpers for the Ethernet egress queue arbiter.
package eth_arb_pkg;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    // End-of-frame flag sits this many bits above the payload MSB + 1.
    localparam int unsigned LAST_POS_FROM_DW = 0;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after lp, with optional port-0 priority.
module rr_pick #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned PW      = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      lp,
    input  logic               prio0_en,
    output logic [PW-1:0]      idx,
    output logic               found
);

    logic [PW:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (prio0_en && req[0]) begin
            found = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= N_PORTS; k++) begin
                // Explicit wrap so non power-of-two port counts never alias.
                cand = {1'b0, lp} + (PW+1)'(k);
                if (cand >= (PW+1)'(N_PORTS)) begin
                    cand = cand - (PW+1)'(N_PORTS);
                end
                if (!found && req[cand[PW-1:0]] && !(prio0_en && cand == '0)) begin
                    found = 1'b1;
                    idx   = cand[PW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/eth_queue_arbiter.sv
// Frame-level round-robin arbiter draining N_PORTS show-ahead queues onto one egress stream.
// Define ETH_ARB_PRIO0_EN to give port 0 strict priority at each arbitration.
module eth_queue_arbiter
    import eth_arb_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_PORTS-1:0]                  q_empty,
    input  logic [N_PORTS*(DATA_WIDTH+1)-1:0]   q_dout,
    output logic [N_PORTS-1:0]                  q_rd_en,
    output logic                                m_valid,
    output logic [DATA_WIDTH-1:0]               m_data,
    output logic                                m_last,
    input  logic                                m_ready,
    output logic [N_PORTS-1:0]                  grant,
    output logic                                busy
);

    localparam int unsigned PW       = ptr_width(N_PORTS);
    localparam int unsigned LAST_POS = DATA_WIDTH + LAST_POS_FROM_DW;
    localparam int unsigned EW       = LAST_POS + 1;

`ifdef ETH_ARB_PRIO0_EN
    localparam bit PRIO0_EN = 1'b1;
`else
    localparam bit PRIO0_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [PW-1:0]   g_q, g_d;
    logic [PW-1:0]   lp_q, lp_d;
    logic [N_PORTS-1:0] req;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [EW-1:0]   head;

    assign req  = ~q_empty;
    assign head = q_dout[int'(g_q)*EW +: EW];

    rr_pick #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_rr_pick (
        .req      (req),
        .lp       (lp_q),
        .prio0_en (PRIO0_EN),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        lp_d    = lp_q;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        q_rd_en = '0;
        grant   = '0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    g_d     = pick_idx;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                busy        = 1'b1;
                grant[g_q]  = 1'b1;
                m_valid     = !q_empty[g_q];
                m_data      = head[DATA_WIDTH-1:0];
                m_last      = head[LAST_POS] & m_valid;
                q_rd_en[g_q] = m_valid & m_ready;
                if (m_valid && m_ready && m_last) begin
                    state_d = StIdle;
                    // With priority, port 0 never advances the rotation of the others.
                    if (!PRIO0_EN || g_q != '0) begin
                        lp_d = g_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            g_q     <= '0;
            lp_q    <= PW'(N_PORTS - 1);
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            lp_q    <= lp_d;
        end
    end

endmodule

// File: doc/eth_queue_arbiter.md
# eth_queue_arbiter

Frame-level round-robin arbiter that drains N_PORTS upstream `queue` FIFOs onto one shared valid/ready egress stream feeding the Ethernet TX path. Each queue entry carries one data beat plus an end-of-frame flag in its MSB. The arbiter grants one queue at a time and holds the grant until that frame's last beat is accepted, so frames are never interleaved. It drives each queue's `rd_en` directly and relies on the queue's show-ahead `dout`.

## Interface
- N_PORTS, 4, number of upstream queues (>= 2)
- DATA_WIDTH, 8, payload bits per beat; queue entries are DATA_WIDTH+1 wide, bit DATA_WIDTH = last
- clk  in  1  single clock
- rst_n  in  1  reset; synchronous, active-low
- q_empty  in  N_PORTS  queue empty flags
- q_dout  in  N_PORTS*(DATA_WIDTH+1)  queue heads; port i at bits [i*(DATA_WIDTH+1) +: DATA_WIDTH+1]
- q_rd_en  out  N_PORTS  pop strobes, at most one bit high per cycle
- m_valid  out  1  egress beat valid
- m_data  out  DATA_WIDTH  egress payload
- m_last  out  1  egress end of frame
- m_ready  in  1  egress accept
- grant  out  N_PORTS  one-hot current owner; all zero when idle
- busy  out  1  high in XFER

## Operation
- States: IDLE, XFER. Registered: state, grant index g (clog2(N_PORTS) bits), last-served pointer lp.
- IDLE: if any q_empty bit is low, pick the first non-empty port scanning lp+1, lp+2, … modulo N_PORTS with wrap. Register g. Next state is XFER. Otherwise stay in IDLE.
- XFER outputs:
  - m_valid = !q_empty[g]
  - m_data = q_dout[g][DATA_WIDTH-1:0]
  - m_last = q_dout[g][DATA_WIDTH] & m_valid
  - q_rd_en[g] = m_valid & m_ready; all other bits 0
- A beat transfers when m_valid & m_ready.
- Transfer with m_last: lp <= g, state goes to IDLE.
- Granted queue empties mid-frame: m_valid drops and the grant is held. No other port is served until the last beat.
- In IDLE: m_valid, m_last, q_rd_en, grant, busy are all 0, and m_data = 0.
- m_ready is ignored in IDLE. A queue that goes non-empty while another port is in XFER waits for the next IDLE arbitration.
- Arithmetic: the pointer wraps modulo N_PORTS. When N_PORTS is not a power of two, the scan index wraps explicitly at N_PORTS-1→0, never through the raw bit width.

## Timing
- Reset values: state = IDLE, g = 0, lp = N_PORTS-1 (so port 0 wins first), all outputs 0.
- Arbitration latency: 1 cycle. A queue non-empty in IDLE at cycle t gives m_valid at t+1.
- Inter-frame gap: exactly one IDLE cycle after each last beat.
- Throughput inside a frame: 1 beat/cycle while the queue is non-empty and m_ready is high.
- q_rd_en is combinational from registered g and the inputs. The pop takes effect at the same edge the beat is accepted.
- Reset asserted mid-frame: return to IDLE at the next edge and drop the grant. The frame tail remains in the queue; the queues are reset by the same rst_n.

## Configuration
- ETH_ARB_PRIO0_EN defined: at each IDLE arbitration, port 0 wins whenever it is non-empty. The remaining ports rotate round-robin among themselves, and lp is updated only when a port other than 0 is served.
- Undefined: pure round-robin across all ports as above.
- Frames are never preempted in either mode.

## Structure
- Package eth_arb_pkg:
  - state typedef (IDLE, XFER)
  - localparam for the last-bit position
  - pointer width function based on $clog2
- Sub-module rr_pick: combinational, inputs request vector + lp (+ prio0 enable), outputs index + found. Instantiated once.
- eth_queue_arbiter holds the FSM, registers and output muxing.

## Test plan
- Single port: port 2 holds a 3-beat frame 0x11, 0x22, 0x33(last), m_ready=1 -> m_valid at t+1, beats on consecutive cycles, q_rd_en = 4'b0100 for 3 cycles, IDLE on the 4th cycle.
- Round-robin: ports 0, 1, 3 each hold a 1-beat frame after reset -> service order 0, 1, 3, each frame separated by one IDLE cycle. Refill port 0 -> served after 3.
- No interleave: port 1 frame of 4 beats, queue empty after beat 2 for 5 cycles, port 0 non-empty -> m_valid=0 and grant=4'b0010 held. Beats 3-4 follow, then port 0 is served.
- Backpressure: m_ready=0 for 3 cycles mid-frame -> m_data stable, q_rd_en=0, no beat lost or duplicated.
- Reset mid-frame: rst_n low during beat 2 of 5 -> next cycle all outputs 0, state IDLE. After release, port 0 is arbitrated first.
- ETH_ARB_PRIO0_EN: ports 0 and 2 continuously refilled -> port 0 wins every arbitration. With port 0 idle, ports 1 and 2 alternate.
